// File: rtl/generate_lane_pipe.sv
// Multi-lane arithmetic combiner: LANES independent add/sub/xor/accumulate lanes
// feeding a STAGES-deep valid/ready pipeline that stalls globally on backpressure.
module generate_lane_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic                   acc_clr,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] y,
    output logic [LANES-1:0]       cout,
    output logic [15:0]            txn_count
);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_XOR = 2'b10,
        MODE_ACC = 2'b11
    } mode_e;

    typedef struct packed {
        logic                   valid;
        logic [LANES*WIDTH-1:0] y;
        logic [LANES-1:0]       cout;
    } slice_t;

    mode_e                  mode_sel;
    logic                   en;
    logic                   accept;
    logic                   clr_en;
    logic [LANES*WIDTH-1:0] y_next;
    logic [LANES-1:0]       c_next;
    slice_t                 pipe_d;
    slice_t                 pipe_q [STAGES];
    logic [15:0]            txn_q;
    logic [15:0]            txn_d;

    assign mode_sel = mode_e'(mode);
    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;
    // A clear is dropped only when a stalled transaction is being offered alongside it.
    assign clr_en   = acc_clr && (en || !in_valid);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] a_l;
        logic [WIDTH-1:0] b_l;
        logic [WIDTH-1:0] acc_q;
        logic [WIDTH-1:0] acc_base;
        logic [WIDTH:0]   sum_add;
        logic [WIDTH:0]   diff;
        logic [WIDTH+1:0] sum_acc;
        logic [WIDTH-1:0] y_l;
        logic             c_l;

        assign a_l      = a[i*WIDTH +: WIDTH];
        assign b_l      = b[i*WIDTH +: WIDTH];
        assign acc_base = acc_clr ? '0 : acc_q;
        assign sum_add  = {1'b0, a_l} + {1'b0, b_l};
        assign diff     = {1'b0, a_l} - {1'b0, b_l};
        assign sum_acc  = {2'b00, acc_base} + {2'b00, a_l} + {2'b00, b_l};

        always_comb begin
            // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
            y_l = '0;
            c_l = 1'b0;
            case (mode_sel)
                MODE_ADD: begin
                    y_l = sum_add[WIDTH-1:0];
                    c_l = sum_add[WIDTH];
                end
                MODE_SUB: begin
                    y_l = diff[WIDTH-1:0];
                    c_l = diff[WIDTH];
                end
                MODE_XOR: y_l = a_l ^ b_l;
                MODE_ACC: begin
                    y_l = sum_acc[WIDTH-1:0];
                    c_l = |sum_acc[WIDTH+1:WIDTH];
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            if (!rst) begin
                acc_q <= '0;
            end else if (accept && mode_sel == MODE_ACC) begin
                acc_q <= sum_acc[WIDTH-1:0];
            end else if (clr_en) begin
                acc_q <= '0;
            end
        end

        assign y_next[i*WIDTH +: WIDTH] = y_l;
        assign c_next[i]                = c_l;
    end

    always_comb begin
        pipe_d.valid = in_valid;
        pipe_d.y     = y_next;
        pipe_d.cout  = c_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data slices are reset too, not just valids, because y/cout must read 0 out of reset.
            for (int s = 0; s < STAGES; s++) pipe_q[s] <= '0;
        end else if (en) begin
            pipe_q[0] <= pipe_d;
            for (int s = 1; s < STAGES; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign txn_d = accept ? txn_q + 16'd1 : txn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) txn_q <= '0;
        else      txn_q <= txn_d;
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign y         = pipe_q[STAGES-1].y;
    assign cout      = pipe_q[STAGES-1].cout;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_generate_lane_pipe.sv
// Scoreboard bench for generate_lane_pipe (WIDTH=8, LANES=4, STAGES=2): stimulus
// pushes expected results, an independent monitor pops and compares on every emit.
module tb_generate_lane_pipe;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_ACC = 2'b11;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic        acc_clr;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [3:0]  cout;
    logic [15:0] txn_count;

    typedef struct packed {
        logic [31:0] ey;
        logic [3:0]  ec;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  macc [4];
    logic [15:0] model_cnt;
    int          total;
    int          bad;
    int          emits;
    int          cyc;

    generate_lane_pipe #(.WIDTH(8), .LANES(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .txn_count (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_txn(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                             input logic clr, output logic [31:0] ey, output logic [3:0] ec);
        int x, z, base, s;
        for (int l = 0; l < 4; l++) begin
            x = int'(av[l*8 +: 8]);
            z = int'(bv[l*8 +: 8]);
            case (m)
                M_ADD: begin s = x + z; ec[l] = (s > 255); end
                M_SUB: begin s = x - z; ec[l] = (x < z);   end
                M_XOR: begin s = x ^ z; ec[l] = 1'b0;      end
                default: begin
                    base    = clr ? 0 : int'(macc[l]);
                    s       = base + x + z;
                    ec[l]   = (s > 255);
                    macc[l] = 8'(s);
                end
            endcase
            ey[l*8 +: 8] = 8'(s);
        end
        model_cnt = model_cnt + 16'd1;
    endtask

    task automatic clear_model();
        for (int l = 0; l < 4; l++) macc[l] = 8'h00;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transaction was accepted.
    task automatic send(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                        input logic clr, input logic use_hand, input logic [31:0] hy,
                        input logic [3:0] hc);
        int          waits;
        logic        took;
        exp_t        e;
        logic [31:0] my;
        logic [3:0]  mc;
        waits    = 0;
        took     = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        acc_clr  = clr;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                took = 1'b1;
                break;
            end
            waits++;
            if (waits > 40) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        if (took) begin
            model_txn(m, av, bv, clr, my, mc);
            e.ey = use_hand ? hy : my;
            e.ec = use_hand ? hc : mc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic idle(input int n, input logic clr);
        in_valid = 1'b0;
        acc_clr  = clr;
        repeat (n) begin
            @(negedge clk);
            if (clr) clear_model();
            @(posedge clk); #1;
        end
        acc_clr = 1'b0;
    endtask

    task automatic do_reset(input logic chk);
        rst = 1'b0;
        #1;
        if (chk) begin
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_y", 64'(y), 64'd0);
            check("reset_cout", 64'(cout), 64'd0);
            check("reset_txn_count", 64'(txn_count), 64'd0);
        end
        sb_q.delete();
        clear_model();
        model_cnt = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        if (chk) check("reset_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compares every emitted result against the scoreboard and watches stalls.
    initial begin
        exp_t        e;
        logic        held;
        logic [31:0] hy;
        logic [3:0]  hc;
        held = 1'b0;
        hy   = '0;
        hc   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
                continue;
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (held) check("stall_hold", 64'({y, cout}), 64'({hy, hc}));
                held = 1'b1;
                hy   = y;
                hc   = cout;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                emits++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got y=%0h cout=%0h with no transaction outstanding", y, cout);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'({y, cout}), 64'({e.ey, e.ec}));
                end
            end
        end
    end

    initial begin
        int          c0;
        int          e0;
        logic [31:0] ra;
        logic [31:0] rb;
        total     = 0;
        bad       = 0;
        emits     = 0;
        model_cnt = '0;
        in_valid  = 1'b0;
        mode      = M_ADD;
        acc_clr   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        clear_model();
        do_reset(1'b1);

        // Add then subtract with hand-computed results.
        send(M_ADD, 32'hFF10_8001, 32'h0120_8001, 1'b0, 1'b1, 32'h0030_0002, 4'b1010);
        send(M_SUB, 32'h0005_0000, 32'h0103_0000, 1'b0, 1'b1, 32'hFF02_0000, 4'b1000);
        send(M_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 1'b1, 32'hFF00_ED34, 4'b0000);
        drain();

        // Accumulate: clear, three accepts, then clear coinciding with an accumulate accept.
        idle(1, 1'b1);
        send(M_ACC, 32'h4040_4040, 32'h4040_4040, 1'b0, 1'b1, 32'h8080_8080, 4'b0000);
        send(M_ACC, 32'h4040_4040, 32'h4040_4040, 1'b0, 1'b1, 32'h0000_0000, 4'b1111);
        send(M_ACC, 32'h4040_4040, 32'h4040_4040, 1'b0, 1'b1, 32'h8080_8080, 4'b0000);
        send(M_ACC, 32'h0101_0101, 32'h0202_0202, 1'b1, 1'b1, 32'h0303_0303, 4'b0000);
        send(M_ACC, 32'h0101_0101, 32'h0000_0000, 1'b0, 1'b1, 32'h0404_0404, 4'b0000);
        drain();
        check("txn_count_directed", 64'(txn_count), 64'(model_cnt));

        // Reset with transactions in flight: nothing stale may emerge afterwards.
        send(M_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '0, '0);
        send(M_ADD, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, '0, '0);
        send(M_ADD, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0, '0, '0);
        do_reset(1'b1);
        e0 = emits;
        idle(5, 1'b0);
        check("reset_no_stale", 64'(emits - e0), 64'd0);

        // Backpressure: six back-to-back sends, output stalled for 4 cycles from cycle 3.
        do_reset(1'b0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++)
                    send(M_ADD, {4{8'(i * 17)}}, 32'h0102_03F0, 1'b0, 1'b0, '0, '0);
            end
        join
        drain();
        check("bp_txn_count", 64'(txn_count), 64'd6);

        // Full throughput with random modes and operands.
        do_reset(1'b0);
        e0 = emits;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(2'($urandom_range(0, 3)), ra, rb, 1'b0, 1'b0, '0, '0);
        end
        check("thr_cycles", 64'(cyc - c0), 64'd20);
        idle(3, 1'b0);
        check("thr_emits", 64'(emits - e0), 64'd20);
        check("thr_txn_count", 64'(txn_count), 64'd20);

        // Counter wrap after 65537 accepts.
        do_reset(1'b0);
        for (int i = 0; i < 65537; i++)
            send(M_ADD, {4{8'(i)}}, 32'h0180_7F01, 1'b0, 1'b0, '0, '0);
        drain();
        check("wrap_txn_count", 64'(txn_count), 64'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
